fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: width of program address.
REQ-002 Parameter BCOND_OP, default 4'b1100: opcode field ir[15:12] marking a conditional branch.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 pc_addr  input  ADDR_WIDTH  current program counter address.
REQ-006 stall  input  1  hold fetch; honoured only in FETCH state.
REQ-007 mem_data_in  input  16  instruction word from synchronous memory; valid one cycle after mem_rd.
REQ-008 flags_in  input  5  processor flags {C,L,F,Z,N}, bit 4 = C.
REQ-009 exec_done  input  1  datapath completion of a non-branch instruction.
REQ-010 mem_rd  output  1  one-cycle instruction read strobe.
REQ-011 mem_addr  output  ADDR_WIDTH  instruction read address.
REQ-012 ir  output  16  instruction register.
REQ-013 exec_start  output  1  one-cycle pulse launching a non-branch instruction.
REQ-014 pc_enable  output  1  one-cycle PC advance strobe.
REQ-015 branch_select  output  1  1 = PC takes prev_addr + disp; 0 = prev_addr + 1.
REQ-016 disp  output  8  branch displacement, ir[7:0] passed unmodified.
REQ-017 prev_addr  output  ADDR_WIDTH  address of the instruction being retired.
REQ-018 retired_count  output  16  count of instructions retired.

Function
REQ-019 FSM states: FETCH, LOAD, DECODE, EXECUTE, UPDATE; one-hot or binary at implementer's choice.
REQ-020 FETCH: stall=0 -> mem_rd=1, mem_addr=pc_addr, prev_addr<=pc_addr, next LOAD; stall=1 -> mem_rd=0, stay FETCH.
REQ-021 LOAD: ir<=mem_data_in; next DECODE.
REQ-022 DECODE: ir[15:12]==BCOND_OP -> latch taken flag from cond ir[11:8] and flags_in this cycle, next UPDATE; otherwise exec_start=1 for this cycle only, taken=0, next EXECUTE.
REQ-023 Condition table (taken when): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 always; 1111 never.
REQ-024 EXECUTE: remain until exec_done=1, then next UPDATE; exec_done in any other state ignored.
REQ-025 UPDATE: pc_enable=1, branch_select=taken, disp=ir[7:0], retired_count+=1; next FETCH.
REQ-026 pc_enable, branch_select, mem_rd, exec_start SHALL be 0 in every state not listed as asserting them.
REQ-027 disp SHALL equal ir[7:0] at all times; prev_addr holds between FETCH captures.
REQ-028 retired_count wraps 16'hFFFF -> 16'h0000 without flag.
REQ-029 Latency: branch instruction FETCH-to-pc_enable 4 cycles; non-branch 5 cycles minimum plus each extra EXECUTE cycle.
REQ-030 Flags changing outside DECODE SHALL not affect branch_select.
REQ-031 stall asserted in LOAD/DECODE/EXECUTE/UPDATE SHALL have no effect; the instruction completes.

Reset
REQ-032 rst=0 at a rising edge, in any state: next state FETCH, ir=0, prev_addr=0, retired_count=0, taken=0, all strobes 0.
REQ-033 Reset mid-EXECUTE abandons the instruction: no pc_enable, retired_count not incremented.
REQ-034 After rst returns to 1, first mem_rd occurs on the first cycle in FETCH with stall=0.

Verification
REQ-035 pc_addr=0x005, mem_data_in=0xC10A (BNE), Z=0 -> pc_enable on 4th cycle, branch_select=1, disp=0x0A, prev_addr=0x005.
REQ-036 Same with mem_data_in=0xC00A (BEQ), Z=0 -> branch_select=0, pc_enable on 4th cycle, retired_count=1.
REQ-037 mem_data_in=0x0123 (non-branch), exec_done raised 3 cycles after exec_start -> pc_enable exactly one cycle after exec_done, branch_select=0.
REQ-038 stall=1 for 6 cycles in FETCH -> no mem_rd for 6 cycles, mem_rd on cycle 7; stall toggled in EXECUTE -> no effect.
REQ-039 rst=0 asserted in EXECUTE -> next cycle state FETCH, ir=0x0000, retired_count=0, no pc_enable; cond 1111 branch -> branch_select=0, cond 1110 -> branch_select=1 regardless of flags.
REQ-040 retired_count preloaded by retiring 65535 instructions, one more retire -> retired_count=0x0000.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Instruction memory port between the fetch controller and a
// synchronous program memory (data returns one cycle after mem_rd).
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  mem_rd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data_in
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data_in
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch/decode sequencer: FETCH, LOAD, DECODE, EXECUTE, UPDATE.
// Evaluates conditional branches and strobes the PC advance.
module fetch_ctrl #(
  parameter int         ADDR_WIDTH = 10,
  parameter logic [3:0] BCOND_OP   = 4'b1100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  input  logic                  stall,
  input  logic [4:0]            flags_in,
  input  logic                  exec_done,
  fetch_ctrl_if.master          bus,
  output logic [15:0]           ir,
  output logic                  exec_start,
  output logic                  pc_enable,
  output logic                  branch_select,
  output logic [7:0]            disp,
  output logic [ADDR_WIDTH-1:0] prev_addr,
  output logic [15:0]           retired_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOAD,
    S_DECODE,
    S_EXECUTE,
    S_UPDATE
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   taken_q;
  logic   cond_met;
  logic   is_branch;
  logic   rd;

  logic fc, fl, ff, fz, fn;

  assign fc = flags_in[4];
  assign fl = flags_in[3];
  assign ff = flags_in[2];
  assign fz = flags_in[1];
  assign fn = flags_in[0];

  assign is_branch    = (ir[15:12] == BCOND_OP);
  assign disp         = ir[7:0];
  assign bus.mem_addr = pc_addr;
  assign bus.mem_rd   = rd;

  // Branch condition evaluated against the live flags.
  always_comb begin
    cond_met = 1'b0;
    unique case (ir[11:8])
      4'b0000: cond_met = fz;
      4'b0001: cond_met = !fz;
      4'b0010: cond_met = fc;
      4'b0011: cond_met = !fc;
      4'b0100: cond_met = fl;
      4'b0101: cond_met = !fl;
      4'b0110: cond_met = fn;
      4'b0111: cond_met = !fn;
      4'b1000: cond_met = ff;
      4'b1001: cond_met = !ff;
      4'b1010: cond_met = !fl && !fz;
      4'b1011: cond_met = fl || fz;
      4'b1100: cond_met = !fn && !fz;
      4'b1101: cond_met = fn || fz;
      4'b1110: cond_met = 1'b1;
      4'b1111: cond_met = 1'b0;
      default: cond_met = 1'b0;
    endcase
  end

  // Next state and strobes; all strobes held low while in reset.
  always_comb begin
    state_d       = state_q;
    rd            = 1'b0;
    exec_start    = 1'b0;
    pc_enable     = 1'b0;
    branch_select = 1'b0;
    if (rst) begin
      unique case (state_q)
        S_FETCH: begin
          if (!stall) begin
            rd      = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: state_d = S_DECODE;
        S_DECODE: begin
          if (is_branch) begin
            state_d = S_UPDATE;
          end else begin
            exec_start = 1'b1;
            state_d    = S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (exec_done) state_d = S_UPDATE;
        end
        S_UPDATE: begin
          pc_enable     = 1'b1;
          branch_select = taken_q;
          state_d       = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Datapath registers: ir, prev_addr, taken flag, retire counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ir            <= '0;
      prev_addr     <= '0;
      retired_count <= '0;
      taken_q       <= 1'b0;
    end else begin
      if (rd) prev_addr <= pc_addr;
      if (state_q == S_LOAD) ir <= bus.mem_data_in;
      if (state_q == S_DECODE) taken_q <= is_branch && cond_met;
      if (state_q == S_UPDATE) retired_count <= retired_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: branch/non-branch timing,
// stall, reset mid-execute, condition codes, counter wrap.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pc_addr;
  logic       stall;
  logic [4:0] flags_in;
  logic       exec_done;
  logic [15:0] ir;
  logic       exec_start;
  logic       pc_enable;
  logic       branch_select;
  logic [7:0] disp;
  logic [9:0] prev_addr;
  logic [15:0] retired_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_ret;

  fetch_ctrl_if #(.ADDR_WIDTH(10)) bus ();

  fetch_ctrl #(.ADDR_WIDTH(10), .BCOND_OP(4'b1100)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_addr       (pc_addr),
    .stall         (stall),
    .flags_in      (flags_in),
    .exec_done     (exec_done),
    .bus           (bus.master),
    .ir            (ir),
    .exec_start    (exec_start),
    .pc_enable     (pc_enable),
    .branch_select (branch_select),
    .disp          (disp),
    .prev_addr     (prev_addr),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one branch from FETCH through UPDATE and back to FETCH.
  task automatic run_branch(input string tag, input logic [15:0] word,
                            input logic [4:0] fl, input logic sel);
    bus.mem_data_in = word;
    flags_in = fl;
    pc_addr = 10'h123;
    #1;
    chk({tag, "_rd"}, {31'd0, bus.mem_rd}, 32'd1);
    step();
    step();
    step();
    #1;
    chk({tag, "_pce"}, {31'd0, pc_enable}, 32'd1);
    chk({tag, "_sel"}, {31'd0, branch_select}, {31'd0, sel});
    chk({tag, "_disp"}, {24'd0, disp}, {24'd0, word[7:0]});
    step();
    exp_ret = exp_ret + 16'd1;
    #1;
    chk({tag, "_ret"}, {16'd0, retired_count}, {16'd0, exp_ret});
  endtask

  initial begin
    rst = 1'b0;
    pc_addr = '0;
    stall = 1'b0;
    flags_in = '0;
    exec_done = 1'b0;
    bus.mem_data_in = '0;
    exp_ret = '0;
    step();
    step();
    #1;
    chk("rst_ir", {16'd0, ir}, 32'h0);
    chk("rst_prev", {22'd0, prev_addr}, 32'h0);
    chk("rst_ret", {16'd0, retired_count}, 32'h0);
    chk("rst_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_pce", {31'd0, pc_enable}, 32'd0);

    // BNE taken with Z=0
    rst = 1'b1;
    pc_addr = 10'h005;
    bus.mem_data_in = 16'hC10A;
    flags_in = 5'b00000;
    #1;
    chk("bne_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("bne_addr", {22'd0, bus.mem_addr}, 32'h005);
    step();
    #1;
    chk("bne_load_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("bne_prev", {22'd0, prev_addr}, 32'h005);
    step();
    #1;
    chk("bne_ir", {16'd0, ir}, 32'hC10A);
    chk("bne_start", {31'd0, exec_start}, 32'd0);
    chk("bne_dec_pce", {31'd0, pc_enable}, 32'd0);
    step();
    flags_in = 5'b00010;
    #1;
    chk("bne_pce", {31'd0, pc_enable}, 32'd1);
    chk("bne_sel", {31'd0, branch_select}, 32'd1);
    chk("bne_disp", {24'd0, disp}, 32'h0A);
    chk("bne_prev2", {22'd0, prev_addr}, 32'h005);
    step();
    exp_ret = 16'd1;
    #1;
    chk("bne_ret", {16'd0, retired_count}, 32'd1);
    chk("bne_after_pce", {31'd0, pc_enable}, 32'd0);

    // BEQ not taken with Z=0; Z toggles in LOAD only
    bus.mem_data_in = 16'hC00A;
    flags_in = 5'b00000;
    step();
    flags_in = 5'b00010;
    step();
    flags_in = 5'b00000;
    step();
    #1;
    chk("beq_pce", {31'd0, pc_enable}, 32'd1);
    chk("beq_sel", {31'd0, branch_select}, 32'd0);
    step();
    exp_ret = 16'd2;
    #1;
    chk("beq_ret", {16'd0, retired_count}, 32'd2);

    // Non-branch, exec_done three cycles after exec_start, stall toggled
    bus.mem_data_in = 16'h0123;
    step();
    step();
    #1;
    chk("nb_start", {31'd0, exec_start}, 32'd1);
    step();
    stall = 1'b1;
    #1;
    chk("nb_ex1_start", {31'd0, exec_start}, 32'd0);
    chk("nb_ex1_pce", {31'd0, pc_enable}, 32'd0);
    step();
    stall = 1'b0;
    #1;
    chk("nb_ex2_pce", {31'd0, pc_enable}, 32'd0);
    step();
    exec_done = 1'b1;
    stall = 1'b1;
    #1;
    chk("nb_ex3_pce", {31'd0, pc_enable}, 32'd0);
    step();
    exec_done = 1'b0;
    stall = 1'b0;
    #1;
    chk("nb_pce", {31'd0, pc_enable}, 32'd1);
    chk("nb_sel", {31'd0, branch_select}, 32'd0);
    step();
    exp_ret = 16'd3;
    #1;
    chk("nb_ret", {16'd0, retired_count}, 32'd3);

    // Stall six cycles in FETCH, then fetch on the seventh
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_rd", {31'd0, bus.mem_rd}, 32'd0);
      step();
    end
    stall = 1'b0;
    run_branch("always", 16'hCE11, 5'b11111, 1'b1);
    run_branch("never", 16'hCF22, 5'b11111, 1'b0);
    run_branch("nlnz", 16'hCA33, 5'b00000, 1'b1);
    run_branch("lz", 16'hCB44, 5'b00000, 1'b0);
    run_branch("carry", 16'hC255, 5'b10000, 1'b1);
    run_branch("nneg", 16'hC766, 5'b00001, 1'b0);

    // Reset mid-EXECUTE abandons the instruction
    bus.mem_data_in = 16'h0456;
    step();
    step();
    step();
    rst = 1'b0;
    exec_done = 1'b1;
    #1;
    chk("rx_pce", {31'd0, pc_enable}, 32'd0);
    step();
    rst = 1'b1;
    exec_done = 1'b0;
    #1;
    chk("rx_ir", {16'd0, ir}, 32'h0);
    chk("rx_ret", {16'd0, retired_count}, 32'h0);
    chk("rx_pce2", {31'd0, pc_enable}, 32'd0);
    chk("rx_rd", {31'd0, bus.mem_rd}, 32'd1);
    exp_ret = 16'd0;

    // Counter wrap from 16'hFFFF
    force dut.retired_count = 16'hFFFF;
    #1;
    release dut.retired_count;
    #1;
    chk("wrap_pre", {16'd0, retired_count}, 32'hFFFF);
    exp_ret = 16'hFFFF;
    run_branch("wrap", 16'hC000, 5'b00010, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
